// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS generator/checker family.
//   - Checker FSM state encoding (kept as plain constants for legacy compatibility)
//   - Standard Fibonacci feedback masks (bit i set = stage i tapped)
//   - Counter width helper
package prbs_pkg;

    localparam logic ST_SEARCH = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    localparam logic [6:0]  PRBS7  = 7'h60;        // x^7  + x^6  + 1
    localparam logic [14:0] PRBS15 = 15'h6000;     // x^15 + x^14 + 1
    localparam logic [22:0] PRBS23 = 23'h420000;   // x^23 + x^18 + 1
    localparam logic [30:0] PRBS31 = 31'h48000000; // x^31 + x^28 + 1

    // Bits needed to hold the values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/prbs_lfsr_core.sv
// Fibonacci LFSR core shared by the PRBS generator and checker.
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous reset, active low (sreg cleared)
//   shift_en  in   advance the register by one bit
//   load_ext  in   1: shift in din (self-sync load), 0: shift in pred (free-run)
//   din       in   external bit used when load_ext=1
//   sreg      out  shift register contents, sreg[0] = most recent bit
//   pred      out  predicted next bit, ^(sreg & TAPS)
module prbs_lfsr_core
    import prbs_pkg::*;
#(
    parameter int unsigned       LFSR_W = 23,
    parameter logic [LFSR_W-1:0] TAPS   = PRBS23
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_en,
    input  logic              load_ext,
    input  logic              din,
    output logic [LFSR_W-1:0] sreg,
    output logic              pred
);

    logic in_bit;

    assign pred   = ^(sreg & TAPS);
    assign in_bit = load_ext ? din : pred;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
        end else if (shift_en) begin
            sreg <= {sreg[LFSR_W-2:0], in_bit};
        end
    end

endmodule

// File: rtl/prbs_stream_checker.sv
// Receive-side PRBS checker: self-synchronises a local LFSR to the incoming
// serial stream, declares lock after LOCK_CNT consecutive correct predictions,
// then free-runs and flags every mismatching bit. Too many errors inside one
// WIN-bit window drop lock and restart the search.
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous reset, active low
//   ena        in   din valid this cycle
//   din        in   received stream bit
//   clr_cnt    in   synchronous clear of err_count (wins over an increment)
//   locked     out  checker is locked to the stream
//   err_pulse  out  one-cycle flag: previous enabled bit mismatched while locked
//   err_count  out  saturating count of mismatches seen while locked
module prbs_stream_checker
    import prbs_pkg::*;
#(
    parameter int unsigned       LFSR_W   = 23,
    parameter logic [LFSR_W-1:0] TAPS     = PRBS23,
    parameter int unsigned       LOCK_CNT = 32,
    parameter int unsigned       WIN      = 64,
    parameter int unsigned       LOSS_ERR = 8,
    parameter int unsigned       ERRCNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                din,
    input  logic                clr_cnt,
    output logic                locked,
    output logic                err_pulse,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int unsigned FILL_W  = cnt_width(LFSR_W);
    localparam int unsigned MATCH_W = cnt_width(LOCK_CNT);
    localparam int unsigned WIN_W   = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int unsigned WERR_W  = cnt_width(LOSS_ERR);

    localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(LFSR_W);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WIN - 1);
    localparam logic [WERR_W-1:0]  WERR_LAST  = WERR_W'(LOSS_ERR - 1);

    logic                state;
    logic [FILL_W-1:0]   fill;
    logic [MATCH_W-1:0]  match;
    logic [WIN_W-1:0]    window;
    logic [WERR_W-1:0]   win_err;

    logic [LFSR_W-1:0]   sreg;
    logic                pred;
    logic                mismatch;
    logic                counted_match;
    logic                count_err;
    logic                lose_lock;

    prbs_lfsr_core #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (ena),
        .load_ext (state == ST_SEARCH),
        .din      (din),
        .sreg     (sreg),
        .pred     (pred)
    );

    assign mismatch = din ^ pred;

    // An all-zero register predicts zero forever; treating it as a miss keeps
    // a dead (constant-0) line from ever looking locked.
    assign counted_match = (fill == FILL_FULL) && (|sreg) && !mismatch;

    assign count_err = ena && (state == ST_LOCKED) && mismatch;
    assign lose_lock = count_err && (win_err == WERR_LAST);

    assign locked = (state == ST_LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SEARCH;
            fill      <= '0;
            match     <= '0;
            window    <= '0;
            win_err   <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= count_err;

            if (clr_cnt) begin
                err_count <= '0;
            end else if (count_err && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end

            if (ena) begin
                if (state == ST_SEARCH) begin
                    if (fill != FILL_FULL) begin
                        fill <= fill + 1'b1;
                    end
                    if (!counted_match) begin
                        match <= '0;
                    end else if (match == MATCH_LAST) begin
                        state   <= ST_LOCKED;
                        match   <= '0;
                        window  <= '0;
                        win_err <= '0;
                    end else begin
                        match <= match + 1'b1;
                    end
                end else begin
                    window <= (window == WIN_LAST) ? '0 : window + 1'b1;
                    // Loss takes precedence over the window wrap on the same bit.
                    if (lose_lock) begin
                        state   <= ST_SEARCH;
                        fill    <= '0;
                        match   <= '0;
                        win_err <= '0;
                    end else if (window == WIN_LAST) begin
                        win_err <= '0;
                    end else if (mismatch) begin
                        win_err <= win_err + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_prbs_stream_checker.sv
// Self-checking bench for prbs_stream_checker (PRBS7 configuration).
// Two instances share the stimulus: u_dut0 (LOSS_ERR=8, 16-bit count) and
// u_dut1 (LOSS_ERR=WIN=64, 4-bit saturating count).
module tb_prbs_stream_checker;

    localparam int unsigned W     = 7;
    localparam int unsigned LOCKN = 32;
    localparam int unsigned WINN  = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        din;
    logic        clr_cnt;
    logic        locked0, pulse0, locked1, pulse1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prbs_stream_checker #(
        .LFSR_W(7), .TAPS(7'h60), .LOCK_CNT(32), .WIN(64), .LOSS_ERR(8), .ERRCNT_W(16)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .clr_cnt(clr_cnt),
        .locked(locked0), .err_pulse(pulse0), .err_count(cnt0)
    );

    prbs_stream_checker #(
        .LFSR_W(7), .TAPS(7'h60), .LOCK_CNT(32), .WIN(64), .LOSS_ERR(64), .ERRCNT_W(4)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .clr_cnt(clr_cnt),
        .locked(locked1), .err_pulse(pulse1), .err_count(cnt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_loss [2] = '{8, 64};
    int m_cmax [2] = '{65535, 15};
    bit m_locked [2];
    bit m_pulse  [2];
    int m_cnt    [2];
    int m_k      [2];          // enabled bits since lock
    bit m_hist   [2][$];       // din bits received since search started
    bit m_ref    [2][$];       // last W bits of the free-running sequence
    int m_errpos [2][$];       // bit positions (since lock) that were errors

    function automatic bit taps_xor(input bit q[$], input int unsigned last);
        logic [6:0] taps_v = 7'h60;
        bit p = 1'b0;
        for (int unsigned i = 0; i < W; i++)
            if (taps_v[i]) p ^= q[last - i];
        return p;
    endfunction

    // Lock when the last LOCKN bits each followed from a full, non-zero history.
    function automatic bit search_locks(input int m);
        int unsigned n = m_hist[m].size();
        if (n < W + LOCKN) return 1'b0;
        for (int unsigned p = n - LOCKN; p < n; p++) begin
            bit any = 1'b0;
            for (int unsigned i = 1; i <= W; i++) any |= m_hist[m][p - i];
            if (!any || taps_xor(m_hist[m], p - 1) != m_hist[m][p]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            m_locked[m] = 1'b0; m_pulse[m] = 1'b0; m_cnt[m] = 0; m_k[m] = 0;
            m_hist[m].delete(); m_ref[m].delete(); m_errpos[m].delete();
        end
    endfunction

    function automatic void model_step(input int m, input bit d, input bit e, input bit c);
        bit err = 1'b0;
        m_pulse[m] = 1'b0;
        if (e) begin
            if (!m_locked[m]) begin
                m_hist[m].push_back(d);
                if (search_locks(m)) begin
                    int unsigned n = m_hist[m].size();
                    m_locked[m] = 1'b1;
                    m_k[m] = 0;
                    m_errpos[m].delete();
                    m_ref[m].delete();
                    for (int unsigned i = n - W; i < n; i++) m_ref[m].push_back(m_hist[m][i]);
                end
            end else begin
                bit p = taps_xor(m_ref[m], W - 1);
                int nwin = 0;
                err = (d != p);
                m_ref[m].push_back(p);
                void'(m_ref[m].pop_front());
                if (err) begin
                    m_pulse[m] = 1'b1;
                    m_errpos[m].push_back(m_k[m]);
                end
                foreach (m_errpos[m][j])
                    if (m_errpos[m][j] / WINN == m_k[m] / WINN) nwin++;
                if (err && nwin == m_loss[m]) begin
                    m_locked[m] = 1'b0;
                    m_hist[m].delete();
                end
                m_k[m]++;
            end
        end
        if (c) m_cnt[m] = 0;
        else if (err && m_cnt[m] < m_cmax[m]) m_cnt[m]++;
    endfunction

    // ---------------- PRBS7 source (b[n] = b[n-7] ^ b[n-6]) ----------------
    bit g_hist [$];
    int en_bits;
    int lock_idx;

    function automatic void gen_seed();
        g_hist = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    endfunction

    function automatic bit gen_next();
        bit b = g_hist[0] ^ g_hist[1];
        void'(g_hist.pop_front());
        g_hist.push_back(b);
        return b;
    endfunction

    task automatic check_outs();
        check("locked0", 32'(locked0), 32'(m_locked[0]));
        check("pulse0",  32'(pulse0),  32'(m_pulse[0]));
        check("count0",  32'(cnt0),    32'(m_cnt[0]));
        check("locked1", 32'(locked1), 32'(m_locked[1]));
        check("pulse1",  32'(pulse1),  32'(m_pulse[1]));
        check("count1",  32'(cnt1),    32'(m_cnt[1]));
    endtask

    task automatic send_raw(input bit b, input bit e, input bit c);
        ena = e; din = b; clr_cnt = c;
        @(posedge clk); #1;
        model_step(0, b, e, c);
        model_step(1, b, e, c);
        if (e) en_bits++;
        if (locked0 && lock_idx == 0) lock_idx = en_bits;
        check_outs();
    endtask

    task automatic send(input bit inv, input bit e, input bit c);
        bit b;
        if (e) b = gen_next() ^ inv;
        else   b = 1'($urandom);
        send_raw(b, e, c);
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        ena = 1'b0; din = 1'b0; clr_cnt = 1'b0;
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_outs();
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check_outs();
        gen_seed();
        en_bits = 0;
        lock_idx = 0;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; din = 1'b0; clr_cnt = 1'b0;
        model_reset();
        gen_seed();
        @(posedge clk); #1;
        check("reset_locked", 32'(locked0), 32'd0);
        check("reset_count",  32'(cnt0),    32'd0);
        do_reset();

        // 1: clean PRBS7, lock after bit 39, no errors
        clean(300);
        check("t1_lock_idx", 32'(lock_idx), 32'd39);
        check("t1_count",    32'(cnt0),     32'd0);

        // 2: single inverted bit while locked
        send(1'b1, 1'b1, 1'b0);
        check("t2_pulse",  32'(pulse0),  32'd1);
        check("t2_count",  32'(cnt0),    32'd1);
        check("t2_locked", 32'(locked0), 32'd1);
        clean(5);
        check("t2_pulse_gone", 32'(pulse0), 32'd0);

        // 3: 8 errors in window 0 -> loss, relock 39 clean bits later
        do_reset();
        clean(40);
        for (int i = 0; i < 7; i++) send(1'b1, 1'b1, 1'b0);
        check("t3_locked_7err", 32'(locked0), 32'd1);
        send(1'b1, 1'b1, 1'b0);
        check("t3_lost",       32'(locked0), 32'd0);
        check("t3_count",      32'(cnt0),    32'd8);
        check("t3_dut1_held",  32'(locked1), 32'd1);
        clean(38);
        check("t3_not_yet",    32'(locked0), 32'd0);
        clean(1);
        check("t3_relock",     32'(locked0), 32'd1);

        // 4: 7 errors per window for 4 windows keeps lock
        do_reset();
        clean(39);
        for (int w = 0; w < 4; w++)
            for (int j = 0; j < 64; j++)
                send(1'((j % 9 == 4) && (j < 63)), 1'b1, 1'b0);
        check("t4_locked", 32'(locked0), 32'd1);
        check("t4_count",  32'(cnt0),    32'd28);

        // 5: constant-0 line never locks
        do_reset();
        for (int i = 0; i < 500; i++) send_raw(1'b0, 1'b1, 1'b0);
        check("t5_never_locked", 32'(lock_idx), 32'd0);
        check("t5_count",        32'(cnt0),     32'd0);

        // 6: same stream with ~50% ena duty
        do_reset();
        for (int i = 0; i < 2000 && en_bits < 300; i++) send(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        check("t6_lock_idx", 32'(lock_idx), 32'd39);
        check("t6_count",    32'(cnt0),     32'd0);

        // 7: clr_cnt alongside a counted error
        send(1'b1, 1'b1, 1'b0);
        check("t7_count_pre", 32'(cnt0), 32'd1);
        send(1'b1, 1'b1, 1'b1);
        check("t7_pulse", 32'(pulse0), 32'd1);
        check("t7_count", 32'(cnt0),   32'd0);
        clean(3);

        // 9: 20 isolated errors, 4-bit counter saturates
        do_reset();
        clean(39);
        for (int i = 0; i < 20; i++) begin
            send(1'b1, 1'b1, 1'b0);
            clean(15);
        end
        check("t9_count_sat",  32'(cnt1),    32'd15);
        check("t9_count_wide", 32'(cnt0),    32'd20);
        check("t9_locked",     32'(locked1), 32'd1);

        // 8: asynchronous reset while locked
        check("t8_pre_locked", 32'(locked0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t8_locked", 32'(locked0), 32'd0);
        check("t8_count",  32'(cnt0),    32'd0);
        check("t8_count1", 32'(cnt1),    32'd0);
        do_reset();

        // random mix: gappy ena, error bursts, occasional clears
        for (int i = 0; i < 1500; i++) begin
            int unsigned rate = ((i / 300) % 2 == 1) ? 5 : 60;
            send(1'($urandom_range(0, rate) == 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 59) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
